// File: rtl/riscv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | riscv_pkg : shared widths, reset PC and the fetch queue entry type     |
// | Revision  : 1.0                                                        |
// +----------------------------------------------------------------------+
package riscv_pkg;

  localparam int          XLEN             = 32;
  localparam int          INST_BYTES       = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_fifo : registered-output queue of fetch entries with flush       |
// | Revision   : 1.0                                                       |
// +----------------------------------------------------------------------+
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  fetch_entry_t  data_i,
  output fetch_entry_t  data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          w_do_push;
  logic          w_do_pop;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == C_DEPTH);
  assign count_o   = count_q;
  assign data_o    = mem_q[rd_ptr_q];
  assign w_do_pop  = pop_i && !empty_o;
  assign w_do_push = push_i && (!full_o || w_do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (w_do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_unit : PC owner, IMEM address driver and decode-facing queue     |
// | Revision   : 1.0                                                       |
// +----------------------------------------------------------------------+
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          IMEM_WORDS = 256,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] inst_addr,
  input  logic [31:0] instruction,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        fetch_err
);

  localparam int          CW           = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] C_IMEM_WORDS = 32'(IMEM_WORDS);

  logic [31:0]   pc_q, pc_d;
  logic          err_q, err_d;
  logic          w_halted;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  fetch_entry_t  w_wr_entry;
  fetch_entry_t  w_head;

  assign w_halted   = ({2'b00, pc_q[31:2]} >= C_IMEM_WORDS);
  assign out_valid  = (w_count != '0);
  assign w_pop      = out_valid && out_ready;
  assign w_push     = !redirect_valid && !w_halted && (!w_full || w_pop);
  assign w_wr_entry = '{pc: pc_q, inst: instruction};

  assign inst_addr  = pc_q;
  assign fetch_err  = err_q;
  assign out_pc     = w_empty ? '0 : w_head.pc;
  assign out_inst   = w_empty ? '0 : w_head.inst;

  // A redirect always loads the word-aligned target, even when misaligned.
  always_comb begin
    pc_d  = pc_q;
    err_d = err_q;
    if (w_halted) err_d = 1'b1;
    if (redirect_valid) begin
      pc_d = {redirect_pc[31:2], 2'b00};
      if (redirect_pc[1:0] != 2'b00) err_d = 1'b1;
    end else if (w_push) begin
      pc_d = pc_q + 32'(INST_BYTES);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= RESET_PC;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .flush_i (redirect_valid),
    .data_i  (w_wr_entry),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fetch_unit : two instances (256 and 4 IMEM words) vs queue model    |
// | Revision      : 1.0                                                    |
// +----------------------------------------------------------------------+
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        out_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  logic [31:0] addr  [2];
  logic [31:0] instr [2];
  logic [31:0] opc   [2];
  logic [31:0] oinst [2];
  logic        ov    [2];
  logic        ferr  [2];

  // IMEM contents: word i holds 0x13 + i.
  assign instr[0] = 32'h13 + (addr[0] >> 2);
  assign instr[1] = 32'h13 + (addr[1] >> 2);

  always #5 clk = ~clk;

  fetch_unit u_dut (
    .clk            (clk),
    .rst            (rst),
    .inst_addr      (addr[0]),
    .instruction    (instr[0]),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (ov[0]),
    .out_ready      (out_ready),
    .out_pc         (opc[0]),
    .out_inst       (oinst[0]),
    .fetch_err      (ferr[0])
  );

  fetch_unit #(.IMEM_WORDS(4)) u_dut_small (
    .clk            (clk),
    .rst            (rst),
    .inst_addr      (addr[1]),
    .instruction    (instr[1]),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (ov[1]),
    .out_ready      (out_ready),
    .out_pc         (opc[1]),
    .out_inst       (oinst[1]),
    .fetch_err      (ferr[1])
  );

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  logic [31:0] m_pc  [2];
  bit          m_err [2];
  int          m_cnt [2];
  logic [63:0] m_ent [2][4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pc[k]  = 32'h0;
      m_err[k] = 1'b0;
      m_cnt[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      logic [31:0] words;
      bit          pop, halted, push;
      words  = (k == 0) ? 32'd256 : 32'd4;
      pop    = (m_cnt[k] > 0) && out_ready;
      halted = (m_pc[k] >> 2) >= words;
      if (halted) m_err[k] = 1'b1;
      if (redirect_valid) begin
        if (redirect_pc[1:0] != 2'b00) m_err[k] = 1'b1;
        m_cnt[k] = 0;
        m_pc[k]  = redirect_pc & 32'hFFFF_FFFC;
      end else begin
        push = !halted && (m_cnt[k] < 2 || pop);
        if (pop) begin
          for (int i = 0; i < 3; i++) m_ent[k][i] = m_ent[k][i+1];
          m_cnt[k]--;
        end
        if (push) begin
          m_ent[k][m_cnt[k]] = {m_pc[k], 32'h13 + (m_pc[k] >> 2)};
          m_cnt[k]++;
          m_pc[k] = m_pc[k] + 32'd4;
        end
      end
    end
  endtask

  task automatic compare_all(input string ph);
    for (int k = 0; k < 2; k++) begin
      string       s;
      logic [63:0] head;
      head = (m_cnt[k] > 0) ? m_ent[k][0] : 64'h0;
      s = $sformatf("%s.u%0d", ph, k);
      check({s, ".valid"},    {31'b0, ov[k]},   {31'b0, m_cnt[k] > 0});
      check({s, ".out_pc"},   opc[k],           head[63:32]);
      check({s, ".out_inst"}, oinst[k],         head[31:0]);
      check({s, ".addr"},     addr[k],          m_pc[k]);
      check({s, ".err"},      {31'b0, ferr[k]}, {31'b0, m_err[k]});
    end
  endtask

  task automatic run_cycle(input string ph, input bit r, input bit rv, input logic [31:0] rpc);
    out_ready      = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
    compare_all(ph);
  endtask

  // Reset pulsed between edges must clear outputs before any clock edge.
  task automatic async_reset_pulse();
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("areset.u%0d.valid", k), {31'b0, ov[k]}, 32'h0);
      check($sformatf("areset.u%0d.addr", k),  addr[k],        32'h0);
      check($sformatf("areset.u%0d.out_pc", k), opc[k],        32'h0);
    end
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    compare_all("reset");
    rst = 1'b0;

    repeat (10) run_cycle("stream", 1'b1, 1'b0, 32'h0);

    @(negedge clk);
    async_reset_pulse();
    repeat (5) run_cycle("bp_hold", 1'b0, 1'b0, 32'h0);
    repeat (6) run_cycle("bp_release", 1'b1, 1'b0, 32'h0);

    repeat (3) run_cycle("pre_redir", 1'b0, 1'b0, 32'h0);
    run_cycle("redir", 1'b0, 1'b1, 32'h40);
    repeat (4) run_cycle("post_redir", 1'b1, 1'b0, 32'h0);

    run_cycle("misalign", 1'b1, 1'b1, 32'h42);
    repeat (4) run_cycle("post_misalign", 1'b1, 1'b0, 32'h0);

    run_cycle("redir0", 1'b1, 1'b1, 32'h0);
    repeat (8) run_cycle("resume", 1'b1, 1'b0, 32'h0);

    for (int n = 0; n < 400; n++) begin
      run_cycle("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                32'($urandom_range(0, 32'h420)));
    end

    run_cycle("mid_redir", 1'b1, 1'b1, 32'h0);
    repeat (3) run_cycle("fill", 1'b0, 1'b0, 32'h0);
    check("fill.u0.count2_valid", {31'b0, ov[0]}, 32'h1);
    async_reset_pulse();
    repeat (6) run_cycle("after_areset", 1'b1, 1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
